// File: rtl/minicpu_pkg.sv
// Shared encodings for the multicycle minicpu control path.
// Holds opcodes, FSM state encoding, ALU operation/control codes and the
// mux-select encodings driven by multicycle_controller.
package minicpu_pkg;

    // Supported RV32I opcodes
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    // Coarse ALU operation chosen by the FSM; refined by alu_decoder
    typedef logic [1:0] alu_op_t;
    localparam alu_op_t ALU_OP_ADD   = 2'b00;
    localparam alu_op_t ALU_OP_SUB   = 2'b01;
    localparam alu_op_t ALU_OP_FUNCT = 2'b10;

    typedef logic [2:0] alu_ctrl_t;
    localparam alu_ctrl_t ALU_ADD = 3'b000;
    localparam alu_ctrl_t ALU_SUB = 3'b001;
    localparam alu_ctrl_t ALU_AND = 3'b010;
    localparam alu_ctrl_t ALU_OR  = 3'b011;
    localparam alu_ctrl_t ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic is_supported(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_R) || (op == OP_I) ||
               (op == OP_BEQ) || (op == OP_JAL);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU control decoder: maps the FSM's coarse alu_op plus instruction fields
// to the 3-bit ALU control code.
//   alu_op      in  2  coarse op from the FSM (add / sub / by funct3)
//   funct3      in  3  instr[14:12]
//   op5         in  1  instr[5], distinguishes R-type from I-type
//   funct7b5    in  1  instr[30]
//   alu_control out 3  ALU operation select
module alu_decoder
    import minicpu_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALU_OP_SUB: alu_control = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // I-type has no subi: funct7b5 is immediate data there
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle minicpu. Steps each instruction through
// fetch/decode/execute/memory/writeback and drives datapath enables and selects.
//   clk, rst     clock and synchronous active-high reset
//   op, funct3, funct7b5  instruction fields; zero  ALU zero flag
//   pc_write, adr_src, mem_write, ir_write, reg_write  enables / address select
//   result_src, alu_src_a, alu_src_b, imm_src, alu_control  mux and ALU selects
//   illegal_op   one-cycle pulse when DECODE sees an unsupported opcode
module multicycle_controller
    import minicpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic [2:0] alu_control,
    output logic       reg_write,
    output logic       illegal_op
);

    state_t  state_q, state_d, cur_state;
    alu_op_t alu_op;
    logic    pc_update, branch, ir_w, mem_w, reg_w, illegal;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECR,
            S_EXECI,
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Under reset the outputs decode as FETCH, even if state_q is mid-instruction
    assign cur_state = rst ? S_FETCH : state_q;

    always_comb begin
        pc_update  = 1'b0;
        branch     = 1'b0;
        alu_op     = ALU_OP_ADD;
        adr_src    = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        illegal    = 1'b0;
        result_src = RES_ALUOUT;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_RD2;
        case (cur_state)
            S_FETCH: begin
                ir_w       = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALURESULT;
                pc_update  = 1'b1;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                illegal   = ~is_supported(op);
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  adr_src = 1'b1;
            S_MEMWB: begin
                result_src = RES_DATA;
                reg_w      = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src = 1'b1;
                mem_w   = 1'b1;
            end
            S_EXECR: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALU_OP_FUNCT;
            end
            S_EXECI: begin
                alu_src_a = SRCA_RD1;
                alu_src_b = SRCB_IMM;
                alu_op    = ALU_OP_FUNCT;
            end
            S_ALUWB:    reg_w = 1'b1;
            S_BEQ: begin
                alu_src_a = SRCA_RD1;
                alu_op    = ALU_OP_SUB;
                branch    = 1'b1;
            end
            S_JAL: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_FOUR;
                pc_update = 1'b1;
            end
            default: ;
        endcase
    end

    assign pc_write   = (pc_update | (branch & zero)) & ~rst;
    assign ir_write   = ir_w & ~rst;
    assign mem_write  = mem_w & ~rst;
    assign reg_write  = reg_w & ~rst;
    assign illegal_op = illegal & ~rst;

    always_comb begin
        case (op)
            OP_LW, OP_I: imm_src = IMM_I;
            OP_SW:       imm_src = IMM_S;
            OP_BEQ:      imm_src = IMM_B;
            OP_JAL:      imm_src = IMM_J;
            default:     imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .op5         (op[5]),
        .funct7b5    (funct7b5),
        .alu_control (alu_control)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;

    localparam logic [6:0] LW  = 7'b0000011;
    localparam logic [6:0] SW  = 7'b0100011;
    localparam logic [6:0] RT  = 7'b0110011;
    localparam logic [6:0] IT  = 7'b0010011;
    localparam logic [6:0] BEQ = 7'b1100011;
    localparam logic [6:0] JAL = 7'b1101111;
    localparam logic [6:0] BAD = 7'b1111111;

    typedef struct packed {
        logic       pcw;
        logic       adr;
        logic       mw;
        logic       irw;
        logic [1:0] rs;
        logic [1:0] a;
        logic [1:0] b;
        logic [1:0] imm;
        logic [2:0] ac;
        logic       rw;
        logic       ill;
    } out_t;

    typedef struct {
        string      name;
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic       z;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;

    int   checks = 0;
    int   failures = 0;
    vec_t vecs[$];
    out_t sb[$];

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk         (clk),
        .rst         (rst),
        .op          (op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .zero        (zero),
        .pc_write    (pc_write),
        .adr_src     (adr_src),
        .mem_write   (mem_write),
        .ir_write    (ir_write),
        .result_src  (result_src),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .imm_src     (imm_src),
        .alu_control (alu_control),
        .reg_write   (reg_write),
        .illegal_op  (illegal_op)
    );

    function automatic out_t o(input logic pcw, input logic adr, input logic mw, input logic irw,
                               input logic [1:0] rs, input logic [1:0] a, input logic [1:0] b,
                               input logic [1:0] imm, input logic [2:0] ac, input logic rw,
                               input logic ill);
        return '{pcw, adr, mw, irw, rs, a, b, imm, ac, rw, ill};
    endfunction

    function automatic out_t fetch_o(input logic [1:0] imm);
        return o(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0, 0);
    endfunction

    function automatic out_t decode_o(input logic [1:0] imm);
        return o(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0, 0);
    endfunction

    function automatic out_t aluwb_o(input logic [1:0] imm);
        return o(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 1, 0);
    endfunction

    task automatic add(input string name, input logic r, input logic [6:0] opc,
                       input logic [2:0] f3, input logic f7, input logic z, input out_t e);
        vec_t v;
        v.name = name; v.rst = r; v.op = opc; v.f3 = f3; v.f7 = f7; v.z = z; v.exp = e;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic out_t sample();
        return '{pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                 imm_src, alu_control, reg_write, illegal_op};
    endfunction

    // Runs one instruction from reset release and measures FETCH-to-FETCH length
    task automatic run_instr(input string name, input logic [6:0] opc, input logic [2:0] f3,
                             input logic z, input int exp_cycles, input int exp_rw);
        int  n = 0;
        int  rw = 0;
        bit  done = 0;
        rst = 1; op = opc; funct3 = f3; funct7b5 = 0; zero = z;
        @(posedge clk); #1;
        rst = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (c > 0 && ir_write) done = 1;
            else begin
                n++;
                if (reg_write) rw++;
            end
            @(posedge clk); #1;
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_cycles"}, 32'(n), 32'(exp_cycles));
        check({name, "_regwr"}, 32'(rw), 32'(exp_rw));
    endtask

    initial begin
        out_t act, exp;

        add("rst0",        1, LW, 3'b010, 0, 0, o(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
        add("rst1",        1, LW, 3'b010, 0, 0, o(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
        add("lw_fetch",    0, LW, 3'b010, 0, 0, fetch_o(2'b00));
        add("lw_decode",   0, LW, 3'b010, 0, 0, decode_o(2'b00));
        add("lw_memadr",   0, LW, 3'b010, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
        add("lw_memread",  0, LW, 3'b010, 0, 0, o(0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
        add("lw_memwb",    0, LW, 3'b010, 0, 0, o(0,0,0,0,2'b01,2'b00,2'b00,2'b00,3'b000,1,0));
        add("sub_fetch",   0, RT, 3'b000, 1, 0, fetch_o(2'b00));
        add("sub_decode",  0, RT, 3'b000, 1, 0, decode_o(2'b00));
        add("sub_execr",   0, RT, 3'b000, 1, 0, o(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0));
        add("sub_aluwb",   0, RT, 3'b000, 1, 0, aluwb_o(2'b00));
        add("add_fetch",   0, RT, 3'b000, 0, 0, fetch_o(2'b00));
        add("add_decode",  0, RT, 3'b000, 0, 0, decode_o(2'b00));
        add("add_execr",   0, RT, 3'b000, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0,0));
        add("add_aluwb",   0, RT, 3'b000, 0, 0, aluwb_o(2'b00));
        add("slt_fetch",   0, RT, 3'b010, 0, 0, fetch_o(2'b00));
        add("slt_decode",  0, RT, 3'b010, 0, 0, decode_o(2'b00));
        add("slt_execr",   0, RT, 3'b010, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b101,0,0));
        add("slt_aluwb",   0, RT, 3'b010, 0, 0, aluwb_o(2'b00));
        add("and_fetch",   0, RT, 3'b111, 0, 0, fetch_o(2'b00));
        add("and_decode",  0, RT, 3'b111, 0, 0, decode_o(2'b00));
        add("and_execr",   0, RT, 3'b111, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b010,0,0));
        add("and_aluwb",   0, RT, 3'b111, 0, 0, aluwb_o(2'b00));
        // addi with instr[30]=1 must still add
        add("addi_fetch",  0, IT, 3'b000, 1, 0, fetch_o(2'b00));
        add("addi_decode", 0, IT, 3'b000, 1, 0, decode_o(2'b00));
        add("addi_execi",  0, IT, 3'b000, 1, 0, o(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
        add("addi_aluwb",  0, IT, 3'b000, 1, 0, aluwb_o(2'b00));
        add("ori_fetch",   0, IT, 3'b110, 0, 0, fetch_o(2'b00));
        add("ori_decode",  0, IT, 3'b110, 0, 0, decode_o(2'b00));
        add("ori_execi",   0, IT, 3'b110, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b011,0,0));
        add("ori_aluwb",   0, IT, 3'b110, 0, 0, aluwb_o(2'b00));
        add("beq1_fetch",  0, BEQ, 3'b000, 0, 1, fetch_o(2'b10));
        add("beq1_decode", 0, BEQ, 3'b000, 0, 1, decode_o(2'b10));
        add("beq1_beq",    0, BEQ, 3'b000, 0, 1, o(1,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,0));
        add("beq0_fetch",  0, BEQ, 3'b000, 0, 0, fetch_o(2'b10));
        add("beq0_decode", 0, BEQ, 3'b000, 0, 0, decode_o(2'b10));
        add("beq0_beq",    0, BEQ, 3'b000, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,0));
        add("jal_fetch",   0, JAL, 3'b000, 0, 0, fetch_o(2'b11));
        add("jal_decode",  0, JAL, 3'b000, 0, 0, decode_o(2'b11));
        add("jal_jal",     0, JAL, 3'b000, 0, 0, o(1,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0,0));
        add("jal_aluwb",   0, JAL, 3'b000, 0, 0, aluwb_o(2'b11));
        add("bad_fetch",   0, BAD, 3'b000, 0, 0, fetch_o(2'b00));
        add("bad_decode",  0, BAD, 3'b000, 0, 0, o(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,1));
        add("sw_fetch",    0, SW, 3'b010, 0, 0, fetch_o(2'b01));
        add("sw_decode",   0, SW, 3'b010, 0, 0, decode_o(2'b01));
        add("sw_memadr",   0, SW, 3'b010, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0));
        add("sw_memwrite", 0, SW, 3'b010, 0, 0, o(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));
        add("swr_fetch",   0, SW, 3'b010, 0, 0, fetch_o(2'b01));
        add("swr_decode",  0, SW, 3'b010, 0, 0, decode_o(2'b01));
        add("swr_memadr",  0, SW, 3'b010, 0, 0, o(0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0));
        // Reset lands in MEMWRITE: enables drop, FETCH selects show
        add("swr_rst",     1, SW, 3'b010, 0, 0, o(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
        add("swr_after",   0, SW, 3'b010, 0, 0, fetch_o(2'b01));
        add("swr_next",    0, SW, 3'b010, 0, 0, decode_o(2'b01));

        rst = 1; op = LW; funct3 = 3'b010; funct7b5 = 0; zero = 0;
        #1;
        foreach (vecs[i]) begin
            rst = vecs[i].rst; op = vecs[i].op; funct3 = vecs[i].f3;
            funct7b5 = vecs[i].f7; zero = vecs[i].z;
            sb.push_back(vecs[i].exp);
            @(negedge clk);
            act = sample();
            exp = sb.pop_front();
            check(vecs[i].name, 32'(act), 32'(exp));
            @(posedge clk); #1;
        end

        run_instr("cnt_lw",  LW,  3'b010, 0, 5, 1);
        run_instr("cnt_sw",  SW,  3'b010, 0, 4, 0);
        run_instr("cnt_r",   RT,  3'b000, 0, 4, 1);
        run_instr("cnt_i",   IT,  3'b000, 0, 4, 1);
        run_instr("cnt_jal", JAL, 3'b000, 0, 4, 1);
        run_instr("cnt_beq", BEQ, 3'b000, 1, 3, 0);
        run_instr("cnt_bad", BAD, 3'b000, 0, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Main control unit of the multicycle minicpu datapath (RV32I subset: lw, sw, R-type ALU, I-type ALU, beq, jal).
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the register file write enable (reg_write to we3), plus memory, PC, instruction-register and mux selects.
- Sits directly upstream of register_file and alu; consumes the instruction register fields and the ALU zero flag.

Parameters:
- none. All encodings are constants in minicpu_pkg.

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  synchronous, active-high reset
- op  in  7  instr[6:0]
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU result == 0
- pc_write  out  1  PC register enable
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction/oldPC register enable
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = oldPC, 10 = rd1 register
- alu_src_b  out  2  00 = rd2 register, 01 = ImmExt, 10 = constant 4
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- reg_write  out  1  register file we3
- illegal_op  out  1  1-cycle pulse: DECODE saw an unsupported opcode

Behaviour:
- Moore FSM with 11 states. The state register updates on posedge clk; rst has priority and loads FETCH. Reset mid-instruction abandons the instruction.
- While rst=1, pc_write, mem_write, ir_write, reg_write and illegal_op are forced to 0. All other outputs show their FETCH values.
- Unlisted outputs are 0 in every state. alu_op is internal.
- FETCH: ir_write=1, adr_src=0, a=00, b=10, alu_op=00, result_src=10, pc_update=1. Next state: DECODE.
- DECODE: a=01, b=01, alu_op=00. Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> FETCH, with illegal_op=1 (instruction treated as NOP)
- MEMADR: a=10, b=01, alu_op=00. Next: MEMREAD if op=lw, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Next: MEMWB.
- MEMWB: result_src=01, reg_write=1. Next: FETCH.
- MEMWRITE: adr_src=1, mem_write=1. Next: FETCH.
- EXECR: a=10, b=00, alu_op=10. Next: ALUWB.
- EXECI: a=10, b=01, alu_op=10. Next: ALUWB.
- ALUWB: result_src=00, reg_write=1. Next: FETCH.
- BEQ: a=10, b=00, alu_op=01, result_src=00, branch=1. Next: FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_update=1. Next: ALUWB.
- pc_write = pc_update | (branch & zero), combinational in the same cycle.
- imm_src is combinational from op, independent of state:
  - lw or I-type -> 00
  - sw -> 01
  - beq -> 10
  - jal -> 11
  - other -> 00
- alu_control is combinational:
  - alu_op=00 -> add
  - alu_op=01 -> sub
  - alu_op=10, by funct3:
    - 000: sub if (op[5] & funct7b5), else add
    - 010: slt
    - 110: or
    - 111: and
    - other: add
  - alu_op=11 -> add
- Cycle counts from FETCH back to FETCH: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.
- reg_write is asserted for exactly one cycle per lw, R, I or jal instruction, and never for sw or beq.

Decomposition:
- minicpu_pkg holds:
  - the opcode localparams (OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL)
  - the state_t enum
  - the alu_op_t and alu_ctrl_t typedefs with their encodings
  - the result_src, alu_src_a, alu_src_b and imm_src encodings
- Sub-module alu_decoder (alu_op, funct3, op5, funct7b5 -> alu_control) is purely combinational and instantiated once.

Test Plan:
- Reset: hold rst=1 for 2 cycles with op=lw -> reg_write=mem_write=pc_write=ir_write=0. After release, FETCH outputs appear: ir_write=1, pc_write=1, alu_src_b=10, result_src=10.
- lw (op=0000011): release reset -> states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH. reg_write=1 only in cycle 5 with result_src=01. imm_src=00 throughout.
- R-type sub (op=0110011, funct3=000, funct7b5=1) -> alu_control=001 in EXECR. ALUWB follows with reg_write=1 and result_src=00. With funct7b5=0 -> 000. With funct3=010 -> 101.
- beq (op=1100011): zero=1 in BEQ -> pc_write=1, alu_control=001, next state FETCH. Repeat with zero=0 -> pc_write=0. reg_write is 0 in both runs.
- jal (op=1101111) -> JAL state has pc_write=1, alu_src_a=01, alu_src_b=10, imm_src=11. Next cycle ALUWB with reg_write=1.
- Illegal op=1111111 -> DECODE pulses illegal_op=1 for one cycle, then FETCH. Separately, assert rst during MEMWRITE of sw -> mem_write drops to 0 that cycle and the next state is FETCH.
